// File: rtl/xgmii_pkt_gen_pkg.sv
// Shared constants, state encoding and helpers for the XGMII frame generator.
// Compile with XGMII_PKT_GEN_CRC_EN defined to put a real CRC-32 in the FCS word.
package xgmii_pkt_gen_pkg;

    // XGMII control/data words in lane order {lane3, lane2, lane1, lane0}
    localparam logic [31:0] XGMII_IDLE_D  = 32'h0707_0707;
    localparam logic [31:0] XGMII_START_D = 32'hfb55_5555;
    localparam logic [31:0] XGMII_SFD_D   = 32'h5555_55d5;
    localparam logic [31:0] XGMII_TERM_D  = 32'hfd07_0707;

    localparam logic [3:0]  XGMII_IDLE_C  = 4'hf;
    localparam logic [3:0]  XGMII_START_C = 4'h8;
    localparam logic [3:0]  XGMII_SFD_C   = 4'h0;
    localparam logic [3:0]  XGMII_TERM_C  = 4'hf;
    localparam logic [3:0]  XGMII_DATA_C  = 4'h0;

    // Shortest frame body and gap the generator will ever produce
    localparam int MIN_LEN_WORDS = 15;
    localparam int MIN_IPG_WORDS = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE0,
        ST_PRE1,
        ST_PAY,
        ST_FCS,
        ST_TERM,
        ST_IPG
    } gen_state_e;

    // Payload word starting at byte value b; bytes wrap modulo 256
    function automatic logic [31:0] pay_word(input logic [7:0] b);
        return {b, b + 8'd1, b + 8'd2, b + 8'd3};
    endfunction

endpackage

// File: rtl/xgmii_pkt_gen_crc32_d32.sv
// IEEE 802.3 CRC-32 (reflected, init all-ones, inverted output), 32 bits per clock.
// Bytes are consumed in wire order: data[31:24] first. Used only when
// XGMII_PKT_GEN_CRC_EN is defined.
module xgmii_crc32_d32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init,
    input  logic        en,
    input  logic [31:0] data,
    output logic [31:0] crc
);

    logic [31:0] crc_q;
    logic [31:0] crc_d;

    // Fold four bytes into the running remainder; init restarts from all-ones
    always_comb begin
        crc_d = init ? 32'hffff_ffff : crc_q;
        for (int k = 3; k >= 0; k--) begin
            crc_d = crc_d ^ {24'd0, data[k*8 +: 8]};
            for (int j = 0; j < 8; j++) begin
                crc_d = crc_d[0] ? ((crc_d >> 1) ^ 32'hedb8_8320) : (crc_d >> 1);
            end
        end
    end

    // Remainder register, advanced on each payload word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= 32'hffff_ffff;
        end else if (en) begin
            crc_q <= crc_d;
        end else if (init) begin
            crc_q <= 32'hffff_ffff;
        end
    end

    assign crc = ~crc_q;

endmodule

// File: rtl/xgmii_pkt_gen.sv
// XGMII 32-bit frame generator: preamble, counting payload, FCS, TERM and a
// programmable idle gap, rotating frames across the enabled ports.
// XGMII_PKT_GEN_CRC_EN selects a real CRC-32 FCS; otherwise the FCS is zero.
module xgmii_pkt_gen
    import xgmii_pkt_gen_pkg::*;
#(
    parameter int PORT_NUM = 4,
    parameter int LEN_W    = 12,
    parameter int IPG_W    = 8,
    parameter int CNT_W    = 32
) (
    input  logic                        I_312m5_clk,
    input  logic                        I_rst_n,
    input  logic                        I_start,
    input  logic                        I_stop,
    input  logic [CNT_W-1:0]            I_frame_num,
    input  logic [LEN_W-1:0]            I_len_words,
    input  logic [IPG_W-1:0]            I_ipg_words,
    input  logic [PORT_NUM-1:0]         I_port_mask,
    output logic [31:0]                 O_xgmii_txd,
    output logic [3:0]                  O_xgmii_txc,
    output logic [$clog2(PORT_NUM)-1:0] O_xgmii_txport_num,
    output logic                        O_busy,
    output logic [CNT_W-1:0]            O_frame_cnt
);

    localparam int PW = $clog2(PORT_NUM);

    gen_state_e          state_q;
    logic [31:0]         txd_q;
    logic [3:0]          txc_q;
    logic [PW-1:0]       port_q;
    logic                busy_q;
    logic [CNT_W-1:0]    frame_cnt_q;
    logic [CNT_W-1:0]    frame_num_q;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    pay_cnt_q;
    logic [IPG_W-1:0]    ipg_q;
    logic [IPG_W-1:0]    ipg_cnt_q;
    logic [PORT_NUM-1:0] mask_q;
    logic [7:0]          byte_q;
    logic                stop_pend_q;

    logic [LEN_W-1:0]    len_clamp_d;
    logic [IPG_W-1:0]    ipg_clamp_d;
    logic [PW-1:0]       first_port_d;
    logic [PW-1:0]       next_port_d;
    logic [31:0]         pay_word_d;
    logic [31:0]         fcs_d;
    logic                done_d;
    logic                stop_now_d;

    assign len_clamp_d = (I_len_words < LEN_W'(MIN_LEN_WORDS)) ? LEN_W'(MIN_LEN_WORDS) : I_len_words;
    assign ipg_clamp_d = (I_ipg_words < IPG_W'(MIN_IPG_WORDS)) ? IPG_W'(MIN_IPG_WORDS) : I_ipg_words;
    assign pay_word_d  = pay_word(byte_q);
    assign done_d      = (frame_num_q != '0) && (frame_cnt_q == frame_num_q);
    assign stop_now_d  = stop_pend_q | I_stop;

    // Lowest set bit of the incoming mask picks the first frame's port
    always_comb begin
        first_port_d = '0;
        for (int i = PORT_NUM - 1; i >= 0; i--) begin
            if (I_port_mask[i]) begin
                first_port_d = PW'(i);
            end
        end
    end

    // Next enabled port above the current one, wrapping; smallest offset wins
    always_comb begin
        next_port_d = port_q;
        for (int i = PORT_NUM; i >= 1; i--) begin
            if (mask_q[(int'(port_q) + i) % PORT_NUM]) begin
                next_port_d = PW'((int'(port_q) + i) % PORT_NUM);
            end
        end
    end

`ifdef XGMII_PKT_GEN_CRC_EN
    logic        crc_en;
    logic [31:0] crc_w;

    assign crc_en = (state_q == ST_PRE1) || ((state_q == ST_PAY) && (pay_cnt_q != len_q));

    xgmii_crc32_d32 u_crc (
        .clk   (I_312m5_clk),
        .rst_n (I_rst_n),
        .init  (state_q == ST_PRE1),
        .en    (crc_en),
        .data  (pay_word_d),
        .crc   (crc_w)
    );

    assign fcs_d = crc_w;
`else
    assign fcs_d = 32'h0000_0000;
`endif

    // Frame sequencer; every output is loaded here so it is registered
    always_ff @(posedge I_312m5_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q     <= ST_IDLE;
            txd_q       <= XGMII_IDLE_D;
            txc_q       <= XGMII_IDLE_C;
            port_q      <= '0;
            busy_q      <= 1'b0;
            frame_cnt_q <= '0;
            frame_num_q <= '0;
            len_q       <= LEN_W'(MIN_LEN_WORDS);
            pay_cnt_q   <= '0;
            ipg_q       <= IPG_W'(MIN_IPG_WORDS);
            ipg_cnt_q   <= '0;
            mask_q      <= '0;
            byte_q      <= '0;
            stop_pend_q <= 1'b0;
        end else begin
            if ((state_q != ST_IDLE) && I_stop) begin
                stop_pend_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    txd_q <= XGMII_IDLE_D;
                    txc_q <= XGMII_IDLE_C;
                    if (I_start && (I_port_mask != '0)) begin
                        state_q     <= ST_PRE0;
                        txd_q       <= XGMII_START_D;
                        txc_q       <= XGMII_START_C;
                        port_q      <= first_port_d;
                        busy_q      <= 1'b1;
                        frame_cnt_q <= '0;
                        frame_num_q <= I_frame_num;
                        len_q       <= len_clamp_d;
                        ipg_q       <= ipg_clamp_d;
                        mask_q      <= I_port_mask;
                        stop_pend_q <= 1'b0;
                    end
                end
                ST_PRE0: begin
                    state_q   <= ST_PRE1;
                    txd_q     <= XGMII_SFD_D;
                    txc_q     <= XGMII_SFD_C;
                    pay_cnt_q <= '0;
                    byte_q    <= '0;
                end
                ST_PRE1: begin
                    state_q   <= ST_PAY;
                    txd_q     <= pay_word_d;
                    txc_q     <= XGMII_DATA_C;
                    byte_q    <= byte_q + 8'd4;
                    pay_cnt_q <= pay_cnt_q + LEN_W'(1);
                end
                ST_PAY: begin
                    txc_q <= XGMII_DATA_C;
                    if (pay_cnt_q == len_q) begin
                        state_q <= ST_FCS;
                        txd_q   <= fcs_d;
                    end else begin
                        txd_q     <= pay_word_d;
                        byte_q    <= byte_q + 8'd4;
                        pay_cnt_q <= pay_cnt_q + LEN_W'(1);
                    end
                end
                ST_FCS: begin
                    state_q     <= ST_TERM;
                    txd_q       <= XGMII_TERM_D;
                    txc_q       <= XGMII_TERM_C;
                    frame_cnt_q <= frame_cnt_q + CNT_W'(1);
                end
                ST_TERM: begin
                    state_q   <= ST_IPG;
                    txd_q     <= XGMII_IDLE_D;
                    txc_q     <= XGMII_IDLE_C;
                    ipg_cnt_q <= IPG_W'(1);
                end
                ST_IPG: begin
                    txd_q <= XGMII_IDLE_D;
                    txc_q <= XGMII_IDLE_C;
                    if (ipg_cnt_q == ipg_q) begin
                        if (done_d || stop_now_d) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= ST_PRE0;
                            txd_q   <= XGMII_START_D;
                            txc_q   <= XGMII_START_C;
                            port_q  <= next_port_d;
                        end
                    end else begin
                        ipg_cnt_q <= ipg_cnt_q + IPG_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    txd_q   <= XGMII_IDLE_D;
                    txc_q   <= XGMII_IDLE_C;
                end
            endcase
        end
    end

    assign O_xgmii_txd        = txd_q;
    assign O_xgmii_txc        = txc_q;
    assign O_xgmii_txport_num = port_q;
    assign O_busy             = busy_q;
    assign O_frame_cnt        = frame_cnt_q;

endmodule

// File: tb/tb_xgmii_pkt_gen.sv
// Directed bench for xgmii_pkt_gen: cycle-by-cycle expected word tables built
// from a small frame model, plus hand sequences for stop, clamp and reset.
module tb_xgmii_pkt_gen;

    localparam int PORT_NUM = 4;
    localparam int LEN_W    = 12;
    localparam int IPG_W    = 8;
    localparam int CNT_W    = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              stop;
    logic [CNT_W-1:0]  frameNum;
    logic [LEN_W-1:0]  lenWords;
    logic [IPG_W-1:0]  ipgWords;
    logic [PORT_NUM-1:0] portMask;
    logic [31:0]       txd;
    logic [3:0]        txc;
    logic [1:0]        txPort;
    logic              busy;
    logic [CNT_W-1:0]  frameCnt;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        start;
        logic        stop;
        logic [31:0] txd;
        logic [3:0]  txc;
        logic [1:0]  port;
        logic        chkPort;
        logic        busy;
        logic [31:0] cnt;
    } vec_t;

    vec_t vecs[$];

    xgmii_pkt_gen #(
        .PORT_NUM (PORT_NUM),
        .LEN_W    (LEN_W),
        .IPG_W    (IPG_W),
        .CNT_W    (CNT_W)
    ) dut (
        .I_312m5_clk        (clk),
        .I_rst_n            (rst_n),
        .I_start            (start),
        .I_stop             (stop),
        .I_frame_num        (frameNum),
        .I_len_words        (lenWords),
        .I_ipg_words        (ipgWords),
        .I_port_mask        (portMask),
        .O_xgmii_txd        (txd),
        .O_xgmii_txc        (txc),
        .O_xgmii_txport_num (txPort),
        .O_busy             (busy),
        .O_frame_cnt        (frameCnt)
    );

    // 312.5 MHz-ish free-running clock (period is arbitrary in simulation)
    always #5 clk = ~clk;

    function automatic logic [31:0] payRef(input int i);
        logic [7:0] b;
        b = 8'((4 * i) % 256);
        return {b, b + 8'd1, b + 8'd2, b + 8'd3};
    endfunction

    function automatic logic [31:0] crcRef(input int lenWords);
        logic [31:0] c;
        c = 32'hffff_ffff;
        for (int n = 0; n < 4 * lenWords; n++) begin
            c = c ^ {24'd0, 8'(n % 256)};
            for (int k = 0; k < 8; k++) begin
                c = c[0] ? ((c >> 1) ^ 32'hedb8_8320) : (c >> 1);
            end
        end
        return ~c;
    endfunction

    function automatic logic [31:0] fcsRef(input int lenWords);
`ifdef XGMII_PKT_GEN_CRC_EN
        return crcRef(lenWords);
`else
        return (lenWords < 0) ? crcRef(0) : 32'h0000_0000;
`endif
    endfunction

    task automatic pushVec(input logic s, input logic [31:0] d, input logic [3:0] c,
                           input logic [1:0] p, input logic cp, input logic b, input int n);
        vec_t v;
        v.start = s; v.stop = 1'b0; v.txd = d; v.txc = c;
        v.port = p; v.chkPort = cp; v.busy = b; v.cnt = 32'(n);
        vecs.push_back(v);
    endtask

    // Expected output stream of one frame; first entry carries the start pulse if asked
    task automatic addFrame(input logic [1:0] port, input int len, input int ipg,
                            input int cntBefore, input logic withStart);
        pushVec(withStart, 32'hfb55_5555, 4'h8, port, 1'b1, 1'b1, cntBefore);
        pushVec(1'b0, 32'h5555_55d5, 4'h0, port, 1'b1, 1'b1, cntBefore);
        for (int i = 0; i < len; i++) begin
            pushVec(1'b0, payRef(i), 4'h0, port, 1'b1, 1'b1, cntBefore);
        end
        pushVec(1'b0, fcsRef(len), 4'h0, port, 1'b1, 1'b1, cntBefore);
        pushVec(1'b0, 32'hfd07_0707, 4'hf, port, 1'b1, 1'b1, cntBefore + 1);
        for (int i = 0; i < ipg; i++) begin
            pushVec(1'b0, 32'h0707_0707, 4'hf, port, 1'b0, 1'b1, cntBefore + 1);
        end
    endtask

    task automatic addIdleEnd(input int cnt);
        pushVec(1'b0, 32'h0707_0707, 4'hf, 2'd0, 1'b0, 1'b0, cnt);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Drive one vector's pulses for exactly one sampling edge
    task automatic applyStimulus(input vec_t v);
        start = v.start;
        stop  = v.stop;
        step();
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic runTable(input string tag, input int injStart, input int injStop);
        vec_t v;
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            if (i == injStart) v.start = 1'b1;
            if (i == injStop)  v.stop  = 1'b1;
            applyStimulus(v);
            checkOutput($sformatf("%s[%0d].txd", tag, i), txd, v.txd);
            checkOutput($sformatf("%s[%0d].txc", tag, i), 32'(txc), 32'(v.txc));
            checkOutput($sformatf("%s[%0d].busy", tag, i), 32'(busy), 32'(v.busy));
            checkOutput($sformatf("%s[%0d].cnt", tag, i), frameCnt, v.cnt);
            if (v.chkPort) begin
                checkOutput($sformatf("%s[%0d].port", tag, i), 32'(txPort), 32'(v.port));
            end
        end
        vecs.delete();
    endtask

    task automatic checkIdleOutputs(input string tag, input int cnt);
        checkOutput({tag, ".txd"}, txd, 32'h0707_0707);
        checkOutput({tag, ".txc"}, 32'(txc), 32'hf);
        checkOutput({tag, ".port"}, 32'(txPort), 32'd0);
        checkOutput({tag, ".busy"}, 32'(busy), 32'd0);
        checkOutput({tag, ".cnt"}, frameCnt, 32'(cnt));
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
        frameNum = '0;
        lenWords = '0;
        ipgWords = '0;
        portMask = '0;

        // Reset values
        repeat (2) step();
        checkIdleOutputs("reset", 0);
        rst_n = 1'b1;
        step();

        // Start with an empty mask is ignored
        frameNum = 32'd1; lenWords = 12'd16; ipgWords = 8'd12; portMask = 4'b0000;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        checkIdleOutputs("zeroMask", 0);

        // Single frame, len 16, ipg 12, port 0
        portMask = 4'b0001;
        addFrame(2'd0, 16, 12, 0, 1'b1);
        addIdleEnd(1);
        runTable("single", -1, -1);

        // Four frames rotating over ports 1 and 3; a start mid-run is ignored
        frameNum = 32'd4; lenWords = 12'd15; ipgWords = 8'd2; portMask = 4'b1010;
        addFrame(2'd1, 15, 2, 0, 1'b1);
        addFrame(2'd3, 15, 2, 1, 1'b0);
        addFrame(2'd1, 15, 2, 2, 1'b0);
        addFrame(2'd3, 15, 2, 3, 1'b0);
        addIdleEnd(4);
        runTable("rotate", 10, -1);

        // Clamped length/gap; start together with stop in IDLE: start wins
        frameNum = 32'd2; lenWords = 12'd3; ipgWords = 8'd0; portMask = 4'b0100;
        addFrame(2'd2, 15, 1, 0, 1'b1);
        addFrame(2'd2, 15, 1, 1, 1'b0);
        addIdleEnd(2);
        runTable("clamp", -1, 0);

        // Continuous run stopped during the second frame's payload
        frameNum = 32'd0; lenWords = 12'd15; ipgWords = 8'd3; portMask = 4'b0011;
        addFrame(2'd0, 15, 3, 0, 1'b1);
        addFrame(2'd1, 15, 3, 1, 1'b0);
        addIdleEnd(2);
        addIdleEnd(2);
        runTable("stop", -1, 29);

        // Stop in IDLE does nothing, then a fresh start is accepted
        frameNum = 32'd1; portMask = 4'b1000;
        addIdleEnd(2);
        addFrame(2'd3, 15, 3, 0, 1'b1);
        addIdleEnd(1);
        runTable("restart", -1, 0);

        // Reset asserted while the second frame's payload word 5 is on the bus
        frameNum = 32'd0; lenWords = 12'd15; ipgWords = 8'd1; portMask = 4'b0011;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (27) step();
        checkOutput("midReset.preTxd", txd, payRef(5));
        checkOutput("midReset.prePort", 32'(txPort), 32'd1);
        checkOutput("midReset.preCnt", frameCnt, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkIdleOutputs("midReset", 0);
        repeat (2) step();
        rst_n = 1'b1;
        step();
        checkIdleOutputs("postReset", 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
